// File: rtl/gestion_verin_pio_pkg.sv
// ============================================================================
// gestion_verin_pio_pkg : register map and pulse-state encoding for the PIO.
// Revision: 1.0
// ============================================================================
`default_nettype none

package gestion_verin_pio_pkg;

   localparam logic [2:0] ADDR_DATA      = 3'd0;
   localparam logic [2:0] ADDR_IRQ       = 3'd2;
   localparam logic [2:0] ADDR_OUTSET    = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
   localparam logic [2:0] ADDR_PULSE_LEN = 3'd6;
   localparam logic [2:0] ADDR_PULSE     = 3'd7;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } pulse_state_e;

endpackage

`default_nettype wire

// File: rtl/gestion_verin_pulse_timer.sv
// ============================================================================
// gestion_verin_pulse_timer : load/retrigger down-counter for the one-shot.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gestion_verin_pulse_timer
   import gestion_verin_pio_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             abort_i,
   input  logic [CNT_W-1:0] len_i,
   output logic             expire_o,
   output logic             active_o
);

   localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   pulse_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A retrigger on the expiry cycle wins, so the old bits are extended.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      expire_o = 1'b0;
      if (abort_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (load_i) begin
         state_d = ACTIVE;
         cnt_d   = len_i - C_ONE;
      end else if (state_q == ACTIVE) begin
         if (cnt_q == '0) begin
            state_d  = IDLE;
            expire_o = 1'b1;
         end else begin
            cnt_d = cnt_q - C_ONE;
         end
      end
   end

   assign active_o = (state_q == ACTIVE);

endmodule

`default_nettype wire

// File: rtl/gestion_verin_pio_out.sv
// ============================================================================
// gestion_verin_pio_out : Avalon-MM output PIO with set/clear and timed pulses.
// Optional: GESTION_VERIN_PIO_PULSE_IRQ_EN adds a pulse-expiry irq output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gestion_verin_pio_out
   import gestion_verin_pio_pkg::*;
#(
   parameter int               WIDTH       = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
`ifdef GESTION_VERIN_PIO_PULSE_IRQ_EN
   output logic             irq,
`endif
   output logic [WIDTH-1:0] out_port
);

   logic [WIDTH-1:0] data_q, data_d, data_w;
   logic [WIDTH-1:0] mask_q, mask_d, mask_w;
   logic [CNT_W-1:0] len_q, len_d;
   logic [31:0]      rd_d;
   logic             wr, pulse_load, abort, expire, active;
   logic [WIDTH-1:0] wd;
   logic             unused_wd;

   assign wr         = chipselect & ~write_n;
   assign wd         = writedata[WIDTH-1:0];
   assign unused_wd  = &{1'b0, writedata};
   assign pulse_load = wr && (address == ADDR_PULSE) && (wd != '0) && (len_q != '0);

   // Bus write effects, before the timer's expiry is folded in.
   always_comb begin
      data_w = data_q;
      mask_w = mask_q;
      len_d  = len_q;
      abort  = 1'b0;
      if (wr) begin
         case (address)
            ADDR_DATA: begin
               data_w = wd;
               mask_w = '0;
               abort  = 1'b1;
            end
            ADDR_OUTSET: begin
               data_w = data_q | wd;
               mask_w = mask_q & ~wd;
               abort  = (mask_w == '0);
            end
            ADDR_OUTCLEAR: begin
               data_w = data_q & ~wd;
               mask_w = mask_q & ~wd;
               abort  = (mask_w == '0);
            end
            ADDR_PULSE_LEN: len_d = writedata[CNT_W-1:0];
            ADDR_PULSE: begin
               if (pulse_load) begin
                  data_w = data_q | wd;
                  mask_w = mask_q | wd;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      data_d = data_w;
      mask_d = mask_w;
      if (expire) begin
         data_d = data_w & ~mask_w;
         mask_d = '0;
      end
   end

   gestion_verin_pulse_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load_i   (pulse_load),
      .abort_i  (abort),
      .len_i    (len_q),
      .expire_o (expire),
      .active_o (active)
   );

`ifdef GESTION_VERIN_PIO_PULSE_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else if (expire) begin
         irq_q <= 1'b1;
      end else if (wr && (address == ADDR_IRQ)) begin
         irq_q <= 1'b0;
      end
   end

   assign irq = irq_q;
`endif

   // Read mux samples the pre-write register values.
   always_comb begin
      rd_d = '0;
      case (address)
         ADDR_DATA:      rd_d[WIDTH-1:0] = data_q;
`ifdef GESTION_VERIN_PIO_PULSE_IRQ_EN
         ADDR_IRQ:       rd_d[0]         = irq_q;
`endif
         ADDR_PULSE_LEN: rd_d[CNT_W-1:0] = len_q;
         ADDR_PULSE:     rd_d[WIDTH-1:0] = mask_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q   <= RESET_VALUE;
         mask_q   <= '0;
         len_q    <= '0;
         readdata <= '0;
      end else begin
         data_q   <= data_d;
         mask_q   <= mask_d;
         len_q    <= len_d;
         readdata <= rd_d;
      end
   end

   assign out_port = data_q;

   logic unused_active;
   assign unused_active = active;

endmodule

`default_nettype wire

// File: tb/tb_gestion_verin_pio_out.sv
// ============================================================================
// tb_gestion_verin_pio_out : directed-vector bench for gestion_verin_pio_out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gestion_verin_pio_out;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [1:0]  out_port;
`ifdef GESTION_VERIN_PIO_PULSE_IRQ_EN
   logic        irq;
`endif

   int n_vec = 0;
   int n_err = 0;

   gestion_verin_pio_out #(
      .WIDTH       (2),
      .RESET_VALUE (2'b00),
      .CNT_W       (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
`ifdef GESTION_VERIN_PIO_PULSE_IRQ_EN
      .irq        (irq),
`endif
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_rd(input logic [2:0] a, output logic [31:0] v);
      address = a;
      tick();
      v = readdata;
   endtask

   initial begin
      logic [31:0] v;
      int c0, c1, f0, f1;
      logic p0, p1, seen_high;

      reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check_vec("reset_readdata", readdata, 32'h0);
      check_vec("reset_out_port", {30'b0, out_port}, 32'h0);

      // DATA / OUTSET / OUTCLEAR
      bus_wr(3'd0, 32'h2);
      check_vec("data_wr", {30'b0, out_port}, 32'h2);
      bus_wr(3'd4, 32'h1);
      check_vec("outset", {30'b0, out_port}, 32'h3);
      bus_wr(3'd5, 32'h2);
      check_vec("outclear", {30'b0, out_port}, 32'h1);
      bus_rd(3'd0, v);
      check_vec("data_rd", v, 32'h1);
      bus_wr(3'd0, 32'h0);
      check_vec("rd_during_wr", readdata, 32'h1);
      check_vec("data_clr", {30'b0, out_port}, 32'h0);

      // Single pulse, length 5
      bus_wr(3'd6, 32'h5);
      bus_rd(3'd6, v);
      check_vec("pulse_len_rd", v, 32'h5);
      bus_wr(3'd7, 32'h1);
      c0 = 0;
      for (int i = 0; i < 12; i++) begin
         if (i == 2) check_vec("mask_active", readdata, 32'h1);
         if (out_port[0]) c0++;
         tick();
      end
      check_vec("pulse5_len", c0, 5);
      check_vec("mask_after", readdata, 32'h0);
      check_vec("pulse5_out", {30'b0, out_port}, 32'h0);

      // Minimum length pulse
      bus_wr(3'd6, 32'h1);
      bus_wr(3'd7, 32'h2);
      c1 = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_port[1]) c1++;
         tick();
      end
      check_vec("pulse1_len", c1, 1);

      // Retrigger: len 10, bit0 at step 0, bit1 at step 4
      bus_wr(3'd6, 32'd10);
      c0 = 0; c1 = 0; f0 = -1; f1 = -1; p0 = 1'b0; p1 = 1'b0;
      for (int i = 0; i < 30; i++) begin
         address = 3'd7;
         if (i == 0 || i == 4) begin
            writedata  = (i == 0) ? 32'h1 : 32'h2;
            chipselect = 1'b1;
            write_n    = 1'b0;
         end else begin
            chipselect = 1'b0;
            write_n    = 1'b1;
         end
         tick();
         if (out_port[0]) c0++;
         if (out_port[1]) c1++;
         if (p0 && !out_port[0] && f0 < 0) f0 = i;
         if (p1 && !out_port[1] && f1 < 0) f1 = i;
         p0 = out_port[0];
         p1 = out_port[1];
      end
      chipselect = 1'b0;
      write_n    = 1'b1;
      check_vec("retrig_bit0", c0, 14);
      check_vec("retrig_bit1", c1, 10);
      check_vec("retrig_fall0", f0, 14);
      check_vec("retrig_fall1", f1, 14);

      // DATA write aborts a pulse and keeps the written value
      bus_wr(3'd6, 32'h8);
      bus_wr(3'd7, 32'h1);
      tick();
      bus_wr(3'd0, 32'h1);
      repeat (12) tick();
      check_vec("abort_out", {30'b0, out_port}, 32'h1);
      bus_rd(3'd7, v);
      check_vec("abort_mask", v, 32'h0);

      // Zero length pulse is ignored
      bus_wr(3'd0, 32'h2);
      bus_wr(3'd6, 32'h0);
      bus_wr(3'd7, 32'h3);
      repeat (3) tick();
      check_vec("len0_out", {30'b0, out_port}, 32'h2);
      bus_rd(3'd7, v);
      check_vec("len0_mask", v, 32'h0);

      // Reset mid-pulse
      bus_wr(3'd0, 32'h0);
      bus_wr(3'd6, 32'h6);
      bus_wr(3'd7, 32'h3);
      check_vec("pre_reset_out", {30'b0, out_port}, 32'h3);
      tick();
      reset = 1'b1;
      tick();
      check_vec("reset_mid_out", {30'b0, out_port}, 32'h0);
      reset = 1'b0;
      seen_high = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_port != 2'b00) seen_high = 1'b1;
      end
      check_vec("no_resume", {31'b0, seen_high}, 32'h0);
      bus_rd(3'd6, v);
      check_vec("reset_len", v, 32'h0);

`ifdef GESTION_VERIN_PIO_PULSE_IRQ_EN
      bus_wr(3'd6, 32'h3);
      bus_wr(3'd7, 32'h1);
      check_vec("irq_idle", {31'b0, irq}, 32'h0);
      repeat (4) tick();
      check_vec("irq_set", {31'b0, irq}, 32'h1);
      bus_rd(3'd2, v);
      check_vec("irq_rd", v, 32'h1);
      bus_wr(3'd2, 32'h0);
      check_vec("irq_clr", {31'b0, irq}, 32'h0);
      bus_wr(3'd7, 32'h1);
      tick();
      bus_wr(3'd0, 32'h0);
      repeat (6) tick();
      check_vec("irq_abort", {31'b0, irq}, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/gestion_verin_pio_out.md
Name: gestion_verin_pio_out

Overview:
- Avalon-MM slave output PIO that drives actuator (verin) control lines from the Nios bus; it is the write-side counterpart of the existing 2-bit input PIO.
- Holds an output data register with atomic set/clear access.
- Adds a hardware one-shot pulse engine: software commands a timed valve/solenoid pulse without polling.
- Sits between the system interconnect and the FPGA pins.

Parameters:
- WIDTH, 2, number of out_port bits (1..32).
- RESET_VALUE, 0, out_port value after reset (WIDTH bits).
- CNT_W, 16, pulse-length counter width in clk cycles (1..32).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data; bits above WIDTH/CNT_W are ignored.
- readdata  out  32  registered read data, zero-extended.
- out_port  out  WIDTH  output pins, driven directly from the data register.

Behaviour:
- Register map (word address):
  - 0 DATA (RW).
  - 1 reserved (reads 0, writes ignored).
  - 2 IRQ (optional feature only, else reads 0).
  - 3 reserved.
  - 4 OUTSET (W, reads 0).
  - 5 OUTCLEAR (W, reads 0).
  - 6 PULSE_LEN (RW, CNT_W bits).
  - 7 PULSE (W; reads return the active pulse mask).
- Reset values: data=RESET_VALUE, readdata=0, pulse_len=0, pulse_mask=0, counter=0, state=IDLE.
- Read path: every cycle, readdata <= mux(address), independent of chipselect.
  - Latency is 1 cycle.
  - A read concurrent with a write returns the pre-write value.
- Write effects are visible on out_port the cycle after the write.
- DATA write: data<=wd. Any active pulse is aborted (pulse_mask<=0, IDLE); bits keep the written value.
- OUTSET: data|=wd, pulse_mask&=~wd. Set bits become sticky and do not auto-clear.
- OUTCLEAR: data&=~wd, pulse_mask&=~wd. If the mask becomes 0, go to IDLE.
- Pulse FSM, states IDLE and ACTIVE:
  - IDLE -> ACTIVE on a PULSE write with wd[WIDTH-1:0]!=0 and pulse_len!=0. Then data|=wd, pulse_mask<=wd, counter<=pulse_len-1.
  - PULSE write with pulse_len=0 or zero mask: ignored, no state change.
  - ACTIVE: counter decrements each cycle. When counter==0: data&=~pulse_mask, pulse_mask<=0, go to IDLE.
  - Net result: each pulsed bit is high for exactly pulse_len cycles.
  - Retrigger: a PULSE write while ACTIVE (including the expiry cycle) gives pulse_mask<=old_mask|wd and counter<=pulse_len-1. Old bits are extended, not cut.
- PULSE_LEN write while ACTIVE changes only the next load; the running count is unaffected.
- pulse_len = all-ones is legal; no wrap occurs because the counter only counts down to 0 and stops.
- Reset asserted mid-pulse: immediate return to reset values; out_port=RESET_VALUE on the next edge.

Optional Feature:
- Macro: GESTION_VERIN_PIO_PULSE_IRQ_EN.
- Defined:
  - Adds port irq, out, 1, level interrupt.
  - irq is set on the cycle a pulse expires naturally. It is not set on abort by DATA or OUTCLEAR.
  - Address 2 reads {31'b0,irq}. Writing any value to address 2 clears irq.
  - If expiry and the clearing write occur in the same cycle, set wins.
  - Reset value is 0.
- Not defined: no irq port; address 2 reads 0 and writes are ignored.

Decomposition:
- Package gestion_verin_pio_pkg holds:
  - Register address constants: ADDR_DATA, ADDR_IRQ, ADDR_OUTSET, ADDR_OUTCLEAR, ADDR_PULSE_LEN, ADDR_PULSE.
  - Pulse state encoding: IDLE, ACTIVE.
- One natural sub-module, gestion_verin_pulse_timer.
  - Contains the load/retrigger down-counter and FSM.
  - Outputs an expire strobe and an active flag.
  - The top level owns the register file and the read mux.

Test Plan:
- Reset, then read DATA -> readdata=0 one cycle after the address is presented; out_port=RESET_VALUE.
- Write DATA=2'b10, then OUTSET=2'b01, then OUTCLEAR=2'b10 -> out_port goes 10, then 11, then 01, each one cycle after its write.
- PULSE_LEN=5, PULSE=2'b01 -> out_port[0] high exactly 5 cycles then low; PULSE reads 01 while active and 00 after.
- PULSE_LEN=10, PULSE=01, then after 4 cycles PULSE=10 -> bit0 high 14 cycles total, bit1 high 10, both fall on the same edge.
- PULSE_LEN=0, PULSE=11 -> no change. Pulse active and reset asserted on cycle 3 -> out_port=RESET_VALUE the next cycle and the pulse does not resume.
- With the macro defined: pulse expiry -> irq=1; write address 2 -> irq=0 next cycle. A DATA-write abort leaves irq=0.
